// File: rtl/ahb5_pkg.sv
// Shared AHB5-Lite encodings, responder FSM states and the byte-lane merge helper.
package ahb5_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  function automatic logic [31:0] merge_bytes(logic [31:0] old_w, logic [31:0] new_w,
                                              logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb5_lane_ctrl.sv
// Decodes transfer size and low address bits into byte-lane enables and a misalignment flag.
import ahb5_pkg::*;

module ahb5_lane_ctrl (
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = '0;
    misalign_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: be_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      HSIZE_WORD: begin
        be_o       = '1;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb5_mem_responder.sv
// AHB5-Lite SRAM subordinate with programmable wait states, byte lanes, a secure
// region and a two-cycle ERROR response.
import ahb5_pkg::*;

module ahb5_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned SEC_BASE_W  = 768
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hready_in,
  input  logic        hnonsec,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [15:0] sec_viol_cnt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;
  logic [31:0]     hrdata_q;
  logic [15:0]     viol_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [3:0]      be_a;
  logic            misalign_a;
  logic            out_of_range, sec_viol, addr_err, accept;
  logic            wr_en, rd_load;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     wr_word, rd_word;
  logic            unused_ok;

  ahb5_lane_ctrl u_lane (
    .hsize_i    (hsize),
    .addr_lo_i  (haddr[1:0]),
    .be_o       (be_a),
    .misalign_o (misalign_a)
  );

  assign hreadyout    = !(state_q inside {ST_WAIT, ST_ERR1});
  assign hresp        = (state_q inside {ST_ERR1, ST_ERR2}) ? RESP_ERROR : RESP_OKAY;
  assign hrdata       = hrdata_q;
  assign sec_viol_cnt = viol_q;

  assign out_of_range = {2'b00, haddr[31:2]} >= 32'(DEPTH_WORDS);
  assign sec_viol     = hnonsec && ({2'b00, haddr[31:2]} >= 32'(SEC_BASE_W));
  assign addr_err     = (hsize > HSIZE_WORD) || misalign_a || out_of_range || sec_viol;
  assign accept       = hsel && hready_in && htrans[1] && hreadyout;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    be_d    = be_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    // A new address phase overrides the idle return from DATA/ERR2 (no bubble).
    if (accept) begin
      widx_d  = haddr[AW+1:2];
      be_d    = be_a;
      write_d = hwrite;
      if (addr_err) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = 3'(WAIT_STATES - 1);
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  // Write retires at the end of its data phase; a read entering DATA on that same
  // edge to the same word sees the merged value.
  assign wr_en   = (state_q == ST_DATA) && write_q && !hreset;
  assign wr_word = merge_bytes(mem[widx_q], hwdata, be_q);
  assign rd_idx  = (state_q == ST_WAIT) ? widx_q : haddr[AW+1:2];
  assign rd_word = (wr_en && (widx_q == rd_idx)) ? wr_word : mem[rd_idx];
  assign rd_load = (state_d == ST_DATA) && !write_d;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      widx_q   <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
      viol_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      be_q    <= be_d;
      write_q <= write_d;
      if (rd_load) hrdata_q <= rd_word;
      if (accept && sec_viol && (viol_q != '1)) viol_q <= viol_q + 16'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en) mem[widx_q] <= wr_word;
  end

  assign unused_ok = ^{hburst, hmastlock, htrans[0]};

endmodule

// File: tb/tb_ahb5_mem_responder.sv
// Randomized bench: two responders (0 and 1 wait states) driven by a pipelined master
// and checked against a word-addressed reference memory and secure-violation count.
module tb_ahb5_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned SEC   = 768;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [2:0]  size;
    bit [31:0] addr;
    bit        ns;
    bit [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hreset [2];
  logic        hsel [2], hwrite [2], hnonsec [2], hmastlock [2];
  logic        hreadyout [2], hresp [2];
  logic [31:0] haddr [2], hwdata [2], hrdata [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize [2], hburst [2];
  logic [15:0] svc [2];

  always #5 clk = ~clk;

  ahb5_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .SEC_BASE_W(768)) u_dut0 (
    .hclk(clk), .hreset(hreset[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hready_in(hreadyout[0]),
    .hnonsec(hnonsec[0]), .hmastlock(hmastlock[0]), .hwdata(hwdata[0]), .hrdata(hrdata[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0]), .sec_viol_cnt(svc[0]));

  ahb5_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .SEC_BASE_W(768)) u_dut1 (
    .hclk(clk), .hreset(hreset[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hready_in(hreadyout[1]),
    .hnonsec(hnonsec[1]), .hmastlock(hmastlock[1]), .hwdata(hwdata[1]), .hrdata(hrdata[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1]), .sec_viol_cnt(svc[1]));

  bit [31:0]   mem_m [int];
  int unsigned viol_m [2];
  int unsigned n_chk = 0, n_pass = 0;
  xfer_t       q [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic xfer_t mk(bit [31:0] addr, bit wr, bit [2:0] size, bit [31:0] wdata,
                               bit ns = 1'b0);
    xfer_t x;
    x.sel = 1'b1; x.trans = 2'b10; x.wr = wr; x.size = size;
    x.addr = addr; x.ns = ns; x.wdata = wdata;
    return x;
  endfunction

  function automatic xfer_t mk_idle(bit sel, bit [1:0] trans);
    xfer_t x;
    x = mk(32'h0, 1'b0, 3'd2, 32'h0);
    x.sel = sel; x.trans = trans;
    return x;
  endfunction

  function automatic bit is_err(xfer_t x);
    int unsigned idx = x.addr / 4;
    if (x.size > 2) return 1'b1;
    if (x.size == 1 && (x.addr % 2) != 0) return 1'b1;
    if (x.size == 2 && (x.addr % 4) != 0) return 1'b1;
    if (idx >= DEPTH) return 1'b1;
    if (x.ns && idx >= SEC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] apply(bit [31:0] old_w, xfer_t x);
    int nbytes = (x.size == 0) ? 1 : (x.size == 1) ? 2 : 4;
    int lane0  = int'(x.addr % 4);
    bit [31:0] res = old_w;
    for (int k = 0; k < nbytes; k++) res[8*(lane0+k) +: 8] = x.wdata[8*(lane0+k) +: 8];
    return res;
  endfunction

  function automatic xfer_t rnd_x();
    int unsigned pool [9] = '{0, 1, 4, 5, 8, 12, 800, 801, 1023};
    int unsigned r = $urandom_range(99);
    int unsigned idx;
    xfer_t x;
    idx = (r < 5) ? 1024 + $urandom_range(3) : pool[$urandom_range(8)];
    x = mk(idx * 4 + $urandom_range(3), 1'($urandom_range(1)),
           ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(2)),
           $urandom, 1'($urandom_range(1)));
    if ($urandom_range(1) == 1) x.trans = 2'b11;
    if (r >= 97)      x.sel = 1'b0;
    else if (r >= 94) x.trans = 2'b01;
    else if (r >= 90) x.trans = 2'b00;
    return x;
  endfunction

  task automatic drive_ap(int d, xfer_t x);
    hsel[d]      = x.sel;
    htrans[d]    = x.trans;
    hwrite[d]    = x.wr;
    hsize[d]     = x.size;
    haddr[d]     = x.addr;
    hnonsec[d]   = x.ns;
    hburst[d]    = 3'($urandom_range(7));
    hmastlock[d] = 1'($urandom_range(1));
  endtask

  // Pipelined master: entered #1 after a posedge with the bus idle, leaves the same way.
  task automatic run(int d, xfer_t xs [$]);
    xfer_t ap, dp, idle_x;
    bit dp_v = 1'b0;
    bit rdy, rsp;
    logic [31:0] rd;
    int waits = 0, cyc = 0, key;
    idle_x = mk_idle(1'b0, 2'b00);
    ap = (xs.size() > 0) ? xs.pop_front() : idle_x;
    drive_ap(d, ap);
    while (1) begin
      @(negedge clk);
      rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
      if (!dp_v) begin
        check("idle_okay", {rdy, rsp}, 2'b10);
      end else if (!rdy) begin
        waits++;
        check("wait_resp", rsp, is_err(dp));
      end else begin
        key = d * 4096 + int'(dp.addr / 4);
        check("latency", waits, is_err(dp) ? 1 : d);
        check("resp", rsp, is_err(dp));
        if (!is_err(dp)) begin
          if (dp.wr) mem_m[key] = apply(mem_m[key], dp);
          else       check("rdata", rd, mem_m[key]);
        end
      end
      if (rdy && xs.size() == 0 && !(ap.sel && ap.trans[1])) break;
      if (++cyc > 2000) begin
        check("timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
      if (rdy) begin
        dp_v = ap.sel && ap.trans[1];
        if (dp_v) begin
          dp = ap;
          waits = 0;
          if (dp.ns && dp.addr / 4 >= SEC && viol_m[d] < 16'hFFFF) viol_m[d]++;
        end
        hwdata[d] = (dp_v && dp.wr) ? dp.wdata : $urandom;
        ap = (xs.size() > 0) ? xs.pop_front() : idle_x;
        drive_ap(d, ap);
      end
    end
    @(posedge clk); #1;
    check("sec_viol_cnt", svc[d], viol_m[d]);
  endtask

  initial begin
    int unsigned pool [9] = '{0, 1, 4, 5, 8, 12, 800, 801, 1023};
    for (int d = 0; d < 2; d++) begin
      hreset[d] = 1'b1; hwdata[d] = '0; viol_m[d] = 0;
      drive_ap(d, mk_idle(1'b0, 2'b00));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", hreadyout[d], 1'b1);
      check("rst_resp", hresp[d], 1'b0);
      check("rst_rdata", hrdata[d], 32'h0);
      check("rst_svc", svc[d], 16'h0);
    end
    @(posedge clk); #1;
    hreset[0] = 1'b0; hreset[1] = 1'b0;

    for (int d = 0; d < 2; d++) begin
      q = {};
      for (int i = 0; i < 9; i++) q.push_back(mk(pool[i] * 4, 1'b1, 3'd2, $urandom));
      run(d, q);
    end

    // word write/read, byte merge, secure region, error classes and idle beats
    q = {};
    q.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
    q.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    q.push_back(mk(32'h10, 1'b1, 3'd2, 32'h11223344));
    q.push_back(mk(32'h13, 1'b1, 3'd0, 32'h55000000));
    q.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    q.push_back(mk(32'd3200, 1'b1, 3'd2, 32'h12345678, 1'b0));
    q.push_back(mk(32'd3200, 1'b1, 3'd2, 32'hFFFF0000, 1'b1));
    q.push_back(mk(32'd3200, 1'b0, 3'd2, 32'h0, 1'b0));
    run(1, q);
    for (int d = 1; d >= 0; d--) begin
      q = {};
      q.push_back(mk(32'h20, 1'b1, 3'd2, 32'hA5A5A5A5));
      q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
      q.push_back(mk(32'h01, 1'b0, 3'd1, 32'h0));
      q.push_back(mk(32'h00, 1'b0, 3'd3, 32'h0));
      q.push_back(mk(32'd4096, 1'b1, 3'd2, 32'hCAFEF00D));
      q.push_back(mk_idle(1'b1, 2'b00));
      q.push_back(mk_idle(1'b1, 2'b01));
      q.push_back(mk_idle(1'b0, 2'b10));
      q.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0));
      run(d, q);
    end

    for (int d = 0; d < 2; d++) begin
      q = {};
      for (int i = 0; i < 150; i++) q.push_back(rnd_x());
      run(d, q);
    end

    // reset while a write waits: the write must never land
    q = {};
    q.push_back(mk(32'h40, 1'b1, 3'd2, 32'h0BADF00D));
    q.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0));
    run(1, q);
    drive_ap(1, mk(32'h40, 1'b1, 3'd2, 32'h0));
    @(posedge clk); #1;
    drive_ap(1, mk_idle(1'b0, 2'b00));
    hwdata[1] = 32'hFFFFFFFF;
    @(negedge clk);
    check("rst6_in_wait", hreadyout[1], 1'b0);
    hreset[1] = 1'b1;
    @(posedge clk); #1;
    hreset[1] = 1'b0;
    viol_m[1] = 0;
    @(negedge clk);
    check("rst6_ready", hreadyout[1], 1'b1);
    check("rst6_resp", hresp[1], 1'b0);
    check("rst6_rdata", hrdata[1], 32'h0);
    @(posedge clk); #1;
    q = {};
    q.push_back(mk(32'h40, 1'b0, 3'd2, 32'h0));
    run(1, q);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
